// File: rtl/step_clock_ctrl_pkg.sv
// Shared encodings for the step-clock controller: operating modes and step FSM states.
package step_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_RUN    = 2'b01,
    MODE_BURST  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } step_state_e;

endpackage

// File: rtl/step_clock_ctrl_btn_debounce_ch.sv
// One push-button channel: 2-flop synchroniser, tick-paced stability counter,
// debounced level and a one-clock rising-edge pulse that trails the level by a clock.
module btn_debounce_ch
  import step_clock_ctrl_pkg::*;
#(
  parameter int STABLE_TICKS = 4
) (
  input  logic clock,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_TICKS);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          rise_q, rise_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick) begin
      if (sync2_q != level_q) begin
        if (cnt_q + CW'(1) == STABLE_C) begin
          level_d = ~level_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
    rise_d = level_q & ~level_prev_q;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      rise_q       <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// Step-clock generator for a single-stepped CPU: debounced buttons drive a
// tick-paced IDLE/HIGH/LOW sequencer in single, run, burst or hold mode.
module step_clock_ctrl
  import step_clock_ctrl_pkg::*;
#(
  parameter int NBTN         = 4,
  parameter int PRESCALE_W   = 19,
  parameter int STABLE_TICKS = 4,
  parameter int STEP_W       = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [NBTN-1:0]   btn,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] burst_len,
  output logic [NBTN-1:0]   btn_level,
  output logic [NBTN-1:0]   btn_rise,
  output logic              cpu_clk,
  output logic [STEP_W-1:0] step_count,
  output logic              busy
);

  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  tick;
  step_state_e           state_q, state_d;
  logic                  pending_q, pending_d;
  logic [STEP_W-1:0]     remaining_q, remaining_d;
  logic [STEP_W-1:0]     step_count_q, step_count_d;
  logic [1:0]            mode_q;
  logic                  mode_chg, more, start;

  assign pre_d = pre_q + PRESCALE_W'(1);
  assign tick  = (pre_q == '0);

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    btn_debounce_ch #(.STABLE_TICKS(STABLE_TICKS)) u_ch (
      .clock   (clock),
      .rst     (rst),
      .tick    (tick),
      .btn_raw (btn[i]),
      .level   (btn_level[i]),
      .rise    (btn_rise[i])
    );
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    remaining_d  = remaining_q;
    step_count_d = step_count_q;
    start        = 1'b0;
    mode_chg     = (mode != mode_q);
    // A mode change abandons queued work; a step already in HIGH still finishes.
    if (mode_chg) begin
      pending_d   = 1'b0;
      remaining_d = '0;
    end
    more = (mode != MODE_HOLD) &&
           ((mode == MODE_RUN) || pending_d || (remaining_d != '0));
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (more) begin
            state_d = ST_HIGH;
            start   = 1'b1;
          end
        end
        ST_HIGH: begin
          state_d      = ST_LOW;
          step_count_d = step_count_q + STEP_W'(1);
        end
        ST_LOW: begin
          if (more) begin
            state_d = ST_HIGH;
            start   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (start) begin
      if (remaining_d != '0) remaining_d = remaining_d - STEP_W'(1);
      else                   pending_d   = 1'b0;
    end
    if (!mode_chg && btn_rise[0] && !busy) begin
      if (mode == MODE_SINGLE)     pending_d   = 1'b1;
      else if (mode == MODE_BURST) remaining_d = burst_len;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pre_q        <= '0;
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      remaining_q  <= '0;
      step_count_q <= '0;
      mode_q       <= MODE_SINGLE;
    end else begin
      pre_q        <= pre_d;
      state_q      <= state_d;
      pending_q    <= pending_d;
      remaining_q  <= remaining_d;
      step_count_q <= step_count_d;
      mode_q       <= mode;
    end
  end

  assign cpu_clk    = (state_q == ST_HIGH);
  assign step_count = step_count_q;
  assign busy       = (state_q != ST_IDLE) || pending_q || (remaining_q != '0);

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Bench for step_clock_ctrl: a tick/step-count model checked every clock plus
// directed scenarios with literal expectations.
module tb_step_clock_ctrl;

  localparam int NBTN = 4;
  localparam int PW   = 2;
  localparam int ST   = 2;
  localparam int SW   = 4;

  logic            clock = 1'b0;
  logic            rst;
  logic [NBTN-1:0] btn;
  logic [1:0]      mode;
  logic [SW-1:0]   burst_len;
  logic [NBTN-1:0] btn_level, btn_rise;
  logic            cpu_clk;
  logic [SW-1:0]   step_count;
  logic            busy;

  int checks = 0;
  int failures = 0;

  step_clock_ctrl #(
    .NBTN(NBTN), .PRESCALE_W(PW), .STABLE_TICKS(ST), .STEP_W(SW)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .btn        (btn),
    .mode       (mode),
    .burst_len  (burst_len),
    .btn_level  (btn_level),
    .btn_rise   (btn_rise),
    .cpu_clk    (cpu_clk),
    .step_count (step_count),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Model: clocks counted in ticks, queued work as a plain "steps owed" number,
  // step phase 0 = none, 1 = clock high, 2 = clock low.
  int              m_pcnt, m_edge, m_phase, m_owed, m_count;
  int              m_run[NBTN];
  int              m_rose[NBTN];
  logic [NBTN-1:0] m_s1, m_s2, m_lvl, m_rise;
  logic [1:0]      m_mode_prev;

  always @(posedge clock or posedge rst) begin
    if (rst) begin
      m_pcnt = 0; m_edge = 0; m_phase = 0; m_owed = 0; m_count = 0;
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_mode_prev = 2'd0;
      for (int i = 0; i < NBTN; i++) begin
        m_run[i]  = 0;
        m_rose[i] = -10;
      end
    end else begin
      bit tk, chg, more, busy_now;
      int owed_n;
      tk       = (m_pcnt == 0);
      m_pcnt   = (m_pcnt + 1) % (1 << PW);
      busy_now = (m_phase != 0) || (m_owed > 0);
      chg      = (mode != m_mode_prev);
      m_mode_prev = mode;
      owed_n   = chg ? 0 : m_owed;
      more     = (mode != 2'd3) && ((mode == 2'd1) || (owed_n > 0));
      if (tk) begin
        if (m_phase == 1) begin
          m_phase = 2;
          m_count = (m_count + 1) % (1 << SW);
        end else if (more) begin
          m_phase = 1;
          if (owed_n > 0) owed_n--;
        end else begin
          m_phase = 0;
        end
      end
      if (!chg && m_rise[0] && !busy_now) begin
        if (mode == 2'd0)      owed_n = 1;
        else if (mode == 2'd2) owed_n = int'(burst_len);
      end
      m_owed = owed_n;
      for (int i = 0; i < NBTN; i++) begin
        if (tk) begin
          if (m_s2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == ST) begin
              m_lvl[i] = ~m_lvl[i];
              m_run[i] = 0;
              if (m_lvl[i]) m_rose[i] = m_edge;
            end
          end else begin
            m_run[i] = 0;
          end
        end
        m_rise[i] = (m_edge == m_rose[i] + 1);
      end
      m_s2 = m_s1;
      m_s1 = btn;
      m_edge++;
    end
  end

  int   hi_cyc = 0, pulses = 0, rises = 0, busy_seen = 0;
  logic prev_cpu = 1'b0;
  int   h0, p0, r0, b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // sel 0: step_count == val, 1: cpu_clk == val, 2: step_count != val
  task automatic wait_for(input int sel, input int val, input int bound, input string name);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done && n < bound) begin
      case (sel)
        0:       done = (int'(step_count) == val);
        1:       done = (int'(cpu_clk) == val);
        default: done = (int'(step_count) != val);
      endcase
      if (!done) begin
        @(negedge clock);
        n++;
      end
    end
    if (!done) chk(name, 0, 1);
  endtask

  task automatic snap();
    h0 = hi_cyc; p0 = pulses; r0 = rises; b0 = busy_seen;
  endtask

  task automatic press(input int ch, input int n);
    btn[ch] = 1'b1;
    clocks(n);
    btn[ch] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn = '0; mode = 2'd0; burst_len = '0;
    fork
      forever begin
        @(negedge clock);
        if (!rst) begin
          chk("btn_level", int'(btn_level), int'(m_lvl));
          chk("btn_rise", int'(btn_rise), int'(m_rise));
          chk("cpu_clk", int'(cpu_clk), int'(m_phase == 1));
          chk("step_count", int'(step_count), m_count);
          chk("busy", int'(busy), int'((m_phase != 0) || (m_owed > 0)));
          if (cpu_clk) hi_cyc++;
          if (cpu_clk && !prev_cpu) pulses++;
          prev_cpu = cpu_clk;
          if (btn_rise[0]) rises++;
          if (busy) busy_seen++;
        end else begin
          prev_cpu = 1'b0;
        end
      end
    join_none

    clocks(3);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_rise", int'(btn_rise), 0);
    chk("rst_cpu_clk", int'(cpu_clk), 0);
    chk("rst_count", int'(step_count), 0);
    chk("rst_busy", int'(busy), 0);
    #1 rst = 1'b0;

    // Bounce shorter than the stability window is filtered out.
    clocks(2);
    snap();
    press(0, 4);
    clocks(20);
    chk("bounce_level", int'(btn_level[0]), 0);
    chk("bounce_rise", rises - r0, 0);
    chk("bounce_count", int'(step_count), 0);

    // Single mode: one press, one step.
    snap();
    btn[0] = 1'b1;
    clocks(12);
    chk("single_level", int'(btn_level[0]), 1);
    btn[0] = 1'b0;
    clocks(48);
    chk("single_count", int'(step_count), 1);
    chk("single_rises", rises - r0, 1);
    chk("single_pulses", pulses - p0, 1);
    chk("single_hi", hi_cyc - h0, 4);
    chk("single_busy", int'(busy), 0);

    // Burst of 5; burst_len changed and a second press while busy do nothing.
    mode = 2'd2; burst_len = 4'd5;
    snap();
    press(0, 12);
    clocks(8);
    burst_len = 4'd9;
    clocks(4);
    press(0, 12);
    clocks(80);
    chk("burst_count", int'(step_count), 6);
    chk("burst_pulses", pulses - p0, 5);
    chk("burst_hi", hi_cyc - h0, 20);
    chk("burst_rises", rises - r0, 2);
    chk("burst_busy", int'(busy), 0);

    // Burst of zero never becomes busy.
    burst_len = 4'd0;
    snap();
    press(0, 12);
    clocks(40);
    chk("burst0_pulses", pulses - p0, 0);
    chk("burst0_busy_seen", busy_seen - b0, 0);
    chk("burst0_count", int'(step_count), 6);

    // Run, then hold while high: the pulse finishes and is counted.
    snap();
    mode = 2'd1;
    wait_for(1, 1, 20, "run_hi_timeout");
    clocks(1);
    mode = 2'd3;
    clocks(24);
    chk("hold_count", int'(step_count), 7);
    chk("hold_pulses", pulses - p0, 1);
    chk("hold_hi", hi_cyc - h0, 4);
    chk("hold_busy", int'(busy), 0);

    // Run through the wrap, then reset in the middle of a high phase.
    mode = 2'd1;
    btn[1] = 1'b1;
    wait_for(0, 15, 200, "cnt15_timeout");
    wait_for(2, 15, 20, "wrap_timeout");
    chk("wrap_count", int'(step_count), 0);
    wait_for(0, 1, 20, "cnt1_timeout");
    wait_for(1, 1, 20, "hi_timeout");
    clocks(1);
    chk("pre_rst_cpu_clk", int'(cpu_clk), 1);
    chk("pre_rst_level1", int'(btn_level[1]), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_cpu_clk", int'(cpu_clk), 0);
    chk("async_count", int'(step_count), 0);
    chk("async_level", int'(btn_level), 0);
    chk("async_busy", int'(busy), 0);
    clocks(2);
    btn = '0;
    mode = 2'd3;
    #1 rst = 1'b0;
    clocks(12);
    chk("post_rst_count", int'(step_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
